// File: rtl/axi_arb_pkg.sv
// Shared types for the IFU/LSU to memory AXI arbiter.
// State encoding and grant identity used by the arbiter and its picker.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_IFU,
        RD_LSU,
        WR_LSU
    } arb_state_t;

    typedef enum logic {
        GNT_IFU,
        GNT_LSU
    } arb_gnt_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker; req[0] is IFU, req[1] is LSU.
// The requester that did not win last time wins a tie.
module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_gnt_t   last,
    output arb_gnt_t   gnt
);

    always_comb begin
        gnt = GNT_IFU;
        if (req[1] && (!req[0] || last == GNT_IFU)) begin
            gnt = GNT_LSU;
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one external AXI master port between IFU reads and LSU reads/writes.
// One single-beat transaction at a time, grant held until its response handshake.
module axi_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   ifu_AR_ADDR,
    input  logic                ifu_AR_VALID,
    output logic                ifu_AR_READY,
    output logic [DATA_W-1:0]   ifu_R_DATA,
    output logic                ifu_R_VALID,
    input  logic                ifu_R_READY,
    input  logic [ADDR_W-1:0]   lsu_AR_ADDR,
    input  logic                lsu_AR_VALID,
    output logic                lsu_AR_READY,
    output logic [DATA_W-1:0]   lsu_R_DATA,
    output logic                lsu_R_VALID,
    input  logic                lsu_R_READY,
    input  logic [ADDR_W-1:0]   lsu_AW_ADDR,
    input  logic                lsu_AW_VALID,
    output logic                lsu_AW_READY,
    input  logic [DATA_W-1:0]   lsu_W_DATA,
    input  logic [DATA_W/8-1:0] lsu_W_STRB,
    input  logic                lsu_W_VALID,
    output logic                lsu_W_READY,
    output logic                lsu_B_VALID,
    input  logic                lsu_B_READY,
    output logic [ADDR_W-1:0]   axi_AR_ADDR,
    output logic                axi_AR_VALID,
    input  logic                axi_AR_READY,
    input  logic [DATA_W-1:0]   axi_R_DATA,
    input  logic                axi_R_VALID,
    output logic                axi_R_READY,
    output logic [ADDR_W-1:0]   axi_AW_ADDR,
    output logic                axi_AW_VALID,
    input  logic                axi_AW_READY,
    output logic [DATA_W-1:0]   axi_W_DATA,
    output logic [DATA_W/8-1:0] axi_W_STRB,
    output logic                axi_W_VALID,
    input  logic                axi_W_READY,
    input  logic                axi_B_VALID,
    output logic                axi_B_READY
);

    arb_state_t state_q, state_d;
    arb_gnt_t   last_q, last_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic       wr_req;
    logic       lsu_req;
    arb_gnt_t   pick;
    logic       rd_lsu;
    logic       x_ar_valid;
    logic       x_r_ready;

    assign wr_req  = lsu_AW_VALID | lsu_W_VALID;
    assign lsu_req = wr_req | lsu_AR_VALID;

    rr_pick2 u_pick (
        .req  ({lsu_req, ifu_AR_VALID}),
        .last (last_q),
        .gnt  (pick)
    );

    // Address/data paths are plain muxes; only the handshakes are gated.
    assign rd_lsu      = (state_q == RD_LSU);
    assign x_ar_valid  = rd_lsu ? lsu_AR_VALID : ifu_AR_VALID;
    assign x_r_ready   = rd_lsu ? lsu_R_READY : ifu_R_READY;
    assign axi_AR_ADDR = rd_lsu ? lsu_AR_ADDR : ifu_AR_ADDR;
    assign axi_AW_ADDR = lsu_AW_ADDR;
    assign axi_W_DATA  = lsu_W_DATA;
    assign axi_W_STRB  = lsu_W_STRB;
    assign ifu_R_DATA  = axi_R_DATA;
    assign lsu_R_DATA  = axi_R_DATA;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        ifu_AR_READY = 1'b0;
        ifu_R_VALID  = 1'b0;
        lsu_AR_READY = 1'b0;
        lsu_R_VALID  = 1'b0;
        lsu_AW_READY = 1'b0;
        lsu_W_READY  = 1'b0;
        lsu_B_VALID  = 1'b0;
        axi_AR_VALID = 1'b0;
        axi_R_READY  = 1'b0;
        axi_AW_VALID = 1'b0;
        axi_W_VALID  = 1'b0;
        axi_B_READY  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (ifu_AR_VALID || lsu_req) begin
                    last_d = pick;
                    if (pick == GNT_IFU) state_d = RD_IFU;
                    else if (wr_req)     state_d = WR_LSU;
                    else                 state_d = RD_LSU;
                end
            end
            RD_IFU, RD_LSU: begin
                axi_AR_VALID = x_ar_valid & ~ar_done_q;
                axi_R_READY  = x_r_ready;
                if (rd_lsu) begin
                    lsu_AR_READY = axi_AR_READY & ~ar_done_q;
                    lsu_R_VALID  = axi_R_VALID;
                end else begin
                    ifu_AR_READY = axi_AR_READY & ~ar_done_q;
                    ifu_R_VALID  = axi_R_VALID;
                end
                if (x_ar_valid && axi_AR_READY) ar_done_d = 1'b1;
                if (axi_R_VALID && x_r_ready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            WR_LSU: begin
                axi_AW_VALID = lsu_AW_VALID & ~aw_done_q;
                lsu_AW_READY = axi_AW_READY & ~aw_done_q;
                axi_W_VALID  = lsu_W_VALID & ~w_done_q;
                lsu_W_READY  = axi_W_READY & ~w_done_q;
                lsu_B_VALID  = axi_B_VALID;
                axi_B_READY  = lsu_B_READY;
                if (lsu_AW_VALID && axi_AW_READY) aw_done_d = 1'b1;
                if (lsu_W_VALID && axi_W_READY)   w_done_d  = 1'b1;
                // An early B is a slave error; still release the port.
                if (axi_B_VALID && lsu_B_READY) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= GNT_LSU;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: arbitration vector table
// followed by hand-written multi-cycle sequences.
module tb_axi_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] IFU_A = 64'h8000_0000;
    localparam logic [63:0] LSU_A = 64'h8000_1000;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ifu_AR_ADDR, lsu_AR_ADDR, lsu_AW_ADDR, axi_AR_ADDR, axi_AW_ADDR;
    logic          ifu_AR_VALID, ifu_AR_READY, ifu_R_VALID, ifu_R_READY;
    logic          lsu_AR_VALID, lsu_AR_READY, lsu_R_VALID, lsu_R_READY;
    logic          lsu_AW_VALID, lsu_AW_READY, lsu_W_VALID, lsu_W_READY;
    logic          lsu_B_VALID, lsu_B_READY;
    logic [DW-1:0] ifu_R_DATA, lsu_R_DATA, lsu_W_DATA, axi_R_DATA, axi_W_DATA;
    logic [DW/8-1:0] lsu_W_STRB, axi_W_STRB;
    logic          axi_AR_VALID, axi_AR_READY, axi_R_VALID, axi_R_READY;
    logic          axi_AW_VALID, axi_AW_READY, axi_W_VALID, axi_W_READY;
    logic          axi_B_VALID, axi_B_READY;

    axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_AR_ADDR(ifu_AR_ADDR), .ifu_AR_VALID(ifu_AR_VALID),
        .ifu_AR_READY(ifu_AR_READY), .ifu_R_DATA(ifu_R_DATA),
        .ifu_R_VALID(ifu_R_VALID), .ifu_R_READY(ifu_R_READY),
        .lsu_AR_ADDR(lsu_AR_ADDR), .lsu_AR_VALID(lsu_AR_VALID),
        .lsu_AR_READY(lsu_AR_READY), .lsu_R_DATA(lsu_R_DATA),
        .lsu_R_VALID(lsu_R_VALID), .lsu_R_READY(lsu_R_READY),
        .lsu_AW_ADDR(lsu_AW_ADDR), .lsu_AW_VALID(lsu_AW_VALID),
        .lsu_AW_READY(lsu_AW_READY), .lsu_W_DATA(lsu_W_DATA),
        .lsu_W_STRB(lsu_W_STRB), .lsu_W_VALID(lsu_W_VALID),
        .lsu_W_READY(lsu_W_READY), .lsu_B_VALID(lsu_B_VALID),
        .lsu_B_READY(lsu_B_READY),
        .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID),
        .axi_AR_READY(axi_AR_READY), .axi_R_DATA(axi_R_DATA),
        .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY),
        .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID),
        .axi_AW_READY(axi_AW_READY), .axi_W_DATA(axi_W_DATA),
        .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID),
        .axi_W_READY(axi_W_READY), .axi_B_VALID(axi_B_VALID),
        .axi_B_READY(axi_B_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] vr;
    logic [6:0]  lsu_vr;
    assign lsu_vr = {lsu_AR_READY, lsu_R_VALID, lsu_AW_READY, lsu_W_READY,
                     lsu_B_VALID, 2'b00};
    assign vr = {ifu_AR_READY, ifu_R_VALID, lsu_vr[6:2], axi_AR_VALID,
                 axi_R_READY, axi_AW_VALID, axi_W_VALID, axi_B_READY};

    int aw_hs = 0, w_hs = 0, r_hs = 0;
    always @(posedge clk) begin
        if (axi_AW_VALID && axi_AW_READY) aw_hs++;
        if (axi_W_VALID && axi_W_READY)   w_hs++;
        if (axi_R_VALID && axi_R_READY)   r_hs++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hs();
        ifu_AR_VALID = 0; ifu_R_READY = 0;
        lsu_AR_VALID = 0; lsu_R_READY = 0;
        lsu_AW_VALID = 0; lsu_W_VALID = 0; lsu_B_READY = 0;
        axi_AR_READY = 0; axi_R_VALID = 0;
        axi_AW_READY = 0; axi_W_READY = 0; axi_B_VALID = 0;
    endtask

    // exp: 0 = no grant, 1 = RD_IFU, 2 = RD_LSU, 3 = WR_LSU
    typedef struct {
        logic ifu_ar;
        logic lsu_ar;
        logic lsu_aw;
        logic lsu_w;
        int   exp;
    } vec_t;

    vec_t v[9];
    int   a0, w0, r0;
    logic rd;

    initial begin
        v[0] = '{1, 0, 0, 0, 1};
        v[1] = '{1, 1, 0, 0, 2};
        v[2] = '{1, 1, 0, 0, 1};
        v[3] = '{0, 1, 1, 1, 3};
        v[4] = '{1, 0, 0, 1, 1};
        v[5] = '{1, 0, 1, 0, 3};
        v[6] = '{0, 1, 0, 0, 2};
        v[7] = '{1, 1, 0, 0, 1};
        v[8] = '{0, 0, 0, 0, 0};

        rst_n = 0;
        clear_hs();
        ifu_AR_ADDR = IFU_A;
        lsu_AR_ADDR = LSU_A;
        lsu_AW_ADDR = 64'h8000_0010;
        lsu_W_DATA  = 64'h1122_3344_5566_7788;
        lsu_W_STRB  = 8'h0F;
        axi_R_DATA  = '0;
        tick();
        tick();
        chk("reset_vr", vr, 0);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            ifu_AR_VALID = v[i].ifu_ar;
            lsu_AR_VALID = v[i].lsu_ar;
            lsu_AW_VALID = v[i].lsu_aw;
            lsu_W_VALID  = v[i].lsu_w;
            #1;
            chk($sformatf("v%0d_idle", i), vr, 0);
            tick();
            rd = (v[i].exp == 1) || (v[i].exp == 2);
            chk($sformatf("v%0d_arv", i), axi_AR_VALID, rd);
            chk($sformatf("v%0d_awv", i), axi_AW_VALID,
                (v[i].exp == 3) && v[i].lsu_aw);
            chk($sformatf("v%0d_wv", i), axi_W_VALID,
                (v[i].exp == 3) && v[i].lsu_w);
            if (rd)
                chk($sformatf("v%0d_addr", i), axi_AR_ADDR,
                    (v[i].exp == 1) ? IFU_A : LSU_A);
            axi_AR_READY = 1; axi_AW_READY = 1; axi_W_READY = 1;
            tick();
            clear_hs();
            if (rd) begin
                axi_R_VALID = 1; axi_R_DATA = 64'h1000 + 64'(i);
                ifu_R_READY = 1; lsu_R_READY = 1;
                #1;
                chk($sformatf("v%0d_ifu_rv", i), ifu_R_VALID, v[i].exp == 1);
                chk($sformatf("v%0d_lsu_rv", i), lsu_R_VALID, v[i].exp == 2);
                tick();
            end else if (v[i].exp == 3) begin
                axi_B_VALID = 1; lsu_B_READY = 1;
                #1;
                chk($sformatf("v%0d_bv", i), lsu_B_VALID, 1);
                tick();
            end
            clear_hs();
        end

        // IFU read alone, data one cycle after AR
        ifu_AR_VALID = 1;
        tick();
        axi_AR_READY = 1;
        #1;
        chk("a_ar_rdy", ifu_AR_READY, 1);
        chk("a_addr", axi_AR_ADDR, 64'h8000_0000);
        chk("a_lsu_quiet", lsu_vr, 0);
        tick();
        clear_hs();
        axi_R_VALID = 1; axi_R_DATA = 64'hDEAD_BEEF; ifu_R_READY = 1;
        #1;
        chk("a_rdata", ifu_R_DATA, 64'hDEAD_BEEF);
        chk("a_rvalid", ifu_R_VALID, 1);
        chk("a_lsu_quiet2", lsu_vr, 0);
        tick();
        clear_hs();
        #1;
        chk("a_idle", vr, 0);

        // LSU write, W two cycles before AW, other requests pending
        a0 = aw_hs; w0 = w_hs;
        lsu_AW_VALID = 1; lsu_W_VALID = 1;
        tick();
        ifu_AR_VALID = 1; lsu_AR_VALID = 1; axi_W_READY = 1;
        #1;
        chk("b_wdata", axi_W_DATA, 64'h1122_3344_5566_7788);
        chk("b_wstrb", axi_W_STRB, 8'h0F);
        chk("b_awaddr", axi_AW_ADDR, 64'h8000_0010);
        chk("b_w_rdy", lsu_W_READY, 1);
        chk("b_aw_rdy0", lsu_AW_READY, 0);
        chk("b_no_ar", axi_AR_VALID, 0);
        tick();
        #1;
        chk("b_w_gated", axi_W_VALID, 0);
        chk("b_w_rdy_gated", lsu_W_READY, 0);
        tick();
        lsu_W_VALID = 0; axi_AW_READY = 1;
        #1;
        chk("b_aw_rdy", lsu_AW_READY, 1);
        tick();
        lsu_AW_VALID = 0; axi_AW_READY = 0; axi_W_READY = 0;
        axi_B_VALID = 1;
        #1;
        chk("b_bvalid", lsu_B_VALID, 1);
        chk("b_no_ar2", axi_AR_VALID, 0);
        tick();
        chk("b_hold", lsu_B_VALID, 1);
        lsu_B_READY = 1;
        tick();
        lsu_B_READY = 0;
        #1;
        chk("b_idle_bv", lsu_B_VALID, 0);
        chk("b_idle_ar", axi_AR_VALID, 0);
        chk("b_aw_once", aw_hs - a0, 1);
        chk("b_w_once", w_hs - w0, 1);
        axi_B_VALID = 0;
        tick();
        axi_AR_READY = 1;
        #1;
        chk("b_rr_addr", axi_AR_ADDR, IFU_A);
        chk("b_rr_ifu", ifu_AR_READY, 1);
        chk("b_rr_lsu", lsu_AR_READY, 0);
        tick();
        ifu_AR_VALID = 0; axi_AR_READY = 0;
        axi_R_VALID = 1; ifu_R_READY = 1;
        tick();
        axi_R_VALID = 0; ifu_R_READY = 0;
        #1;
        chk("b_bubble", vr, 0);
        tick();
        axi_AR_READY = 1;
        #1;
        chk("b_lsu_rdy", lsu_AR_READY, 1);
        chk("b_lsu_addr", axi_AR_ADDR, LSU_A);
        tick();
        clear_hs();
        axi_R_VALID = 1; lsu_R_READY = 1;
        tick();
        clear_hs();

        // R delayed 5 cycles while IFU toggles R_READY
        ifu_AR_VALID = 1;
        tick();
        axi_AR_READY = 1;
        tick();
        clear_hs();
        r0 = r_hs;
        for (int k = 0; k < 5; k++) begin
            ifu_R_READY = k[0];
            #1;
            chk($sformatf("c_rrdy%0d", k), axi_R_READY, k[0]);
            chk($sformatf("c_rv%0d", k), ifu_R_VALID, 0);
            tick();
        end
        axi_R_VALID = 1; axi_R_DATA = 64'hCAFE_F00D; ifu_R_READY = 1;
        #1;
        chk("c_rv", ifu_R_VALID, 1);
        chk("c_rdata", ifu_R_DATA, 64'hCAFE_F00D);
        tick();
        clear_hs();
        #1;
        chk("c_done", ifu_R_VALID, 0);
        chk("c_once", r_hs - r0, 1);

        // Reset in RD_LSU after the AR handshake
        lsu_AR_VALID = 1;
        tick();
        axi_AR_READY = 1;
        tick();
        lsu_AR_VALID = 0; axi_AR_READY = 0; axi_R_VALID = 1;
        #1;
        chk("d_pre_rv", lsu_R_VALID, 1);
        rst_n = 0;
        #1;
        chk("d_rst_vr", vr, 0);
        tick();
        tick();
        clear_hs();
        rst_n = 1;
        ifu_AR_VALID = 1; lsu_AR_VALID = 1;
        #1;
        chk("d_idle", vr, 0);
        tick();
        axi_AR_READY = 1;
        #1;
        chk("d_ifu_first", ifu_AR_READY, 1);
        chk("d_lsu_wait", lsu_AR_READY, 0);
        clear_hs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
